// File: rtl/hamming_pkg.sv
// hamming_pkg
//   Shared constants and types for the (7,4) Hamming decode arbiter:
//   codeword/data widths, parity-type encodings and the result-stage FSM
//   state encoding.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/hamming_decode_arbiter_if.sv
// hamming_decode_arbiter_if
//   Handshake bundle between the two requesters, the arbiter and the
//   downstream consumer.
//   req0_* / req1_* : valid/ready request channels (codeword [7:1], parity type)
//   out_*           : valid/ready result channel (corrected word, error, channel)
//   modport slave   : arbiter side
//   modport master  : requester/consumer side
interface hamming_decode_arbiter_if;
  import hamming_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [CODE_W:1]   req0_code;
  logic              req0_parity_type;
  logic              req1_valid;
  logic              req1_ready;
  logic [CODE_W:1]   req1_code;
  logic              req1_parity_type;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W:1]   out_data;
  logic              out_error;
  logic              out_chan;

  modport slave (
    input  req0_valid, req0_code, req0_parity_type,
    input  req1_valid, req1_code, req1_parity_type,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_error, out_chan,
    input  out_ready
  );

  modport master (
    output req0_valid, req0_code, req0_parity_type,
    output req1_valid, req1_code, req1_parity_type,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_error, out_chan,
    output out_ready
  );

endinterface

// File: rtl/hamming_error_correction.sv
// hamming_error_correction
//   Combinational (7,4) Hamming single-error corrector.
//   code_in     : received codeword [7:1], parity bits at positions 1,2,4
//   parity_type : 0 = even, 1 = odd (odd inverts every syndrome bit)
//   code_out    : codeword with bit c[syndrome] flipped when syndrome != 0
//   error       : 1 when the syndrome is nonzero
module hamming_error_correction
  import hamming_pkg::*;
(
  input  logic [CODE_W:1] code_in,
  input  logic            parity_type,
  output logic [CODE_W:1] code_out,
  output logic            error
);

  logic [2:0] syn;

  always_comb begin
    syn[0] = ^{code_in[1], code_in[3], code_in[5], code_in[7]} ^ parity_type;
    syn[1] = ^{code_in[2], code_in[3], code_in[6], code_in[7]} ^ parity_type;
    syn[2] = ^{code_in[4], code_in[5], code_in[6], code_in[7]} ^ parity_type;
    error  = |syn;
    code_out = code_in;
    for (int i = 1; i <= CODE_W; i++) begin
      code_out[i] = code_in[i] ^ (syn == 3'(i));
    end
  end

endmodule

// File: rtl/hamming_decode_arbiter.sv
// hamming_decode_arbiter
//   Two-channel arbiter in front of one shared Hamming (7,4) corrector, with
//   a one-entry valid/ready result register and per-channel error counters.
//   clk, rst (sync, active-high) : clock and reset
//   bus (slave)                  : request channels and result channel
//   cnt_clear                    : clears both error counters
//   err_cnt0/err_cnt1            : saturating corrected-error counts
//   Macro HAMMING_ARB_STATS_EN builds the counters; otherwise they read 0.
//
//   state    | meaning
//   ST_EMPTY | result register empty, any valid request may be granted
//   ST_FULL  | result register holds a result, grant only if out_ready
module hamming_decode_arbiter
  import hamming_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int PRIO_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  hamming_decode_arbiter_if.slave bus,
  input  logic                  cnt_clear,
  output logic [CNT_W-1:0]      err_cnt0,
  output logic [CNT_W-1:0]      err_cnt1
);

  arb_state_e      state_q, state_d;
  logic [CODE_W:1] out_data_q, out_data_d;
  logic            out_error_q, out_error_d;
  logic            out_chan_q, out_chan_d;
  logic            last_grant_q, last_grant_d;

  logic            grant_ok, win1, gnt0, gnt1, grant;
  logic [CODE_W:1] sel_code, corr_code;
  logic            sel_parity, corr_err;

  // A full register can take a new result in the same cycle it drains.
  always_comb begin
    grant_ok = (state_q == ST_EMPTY) || bus.out_ready;
    if (PRIO_MODE != 0) begin
      win1 = bus.req1_valid & ~bus.req0_valid;
    end else begin
      win1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    end
    gnt1       = grant_ok & win1;
    gnt0       = grant_ok & bus.req0_valid & ~win1;
    grant      = gnt0 | gnt1;
    sel_code   = win1 ? bus.req1_code : bus.req0_code;
    sel_parity = win1 ? bus.req1_parity_type : bus.req0_parity_type;
  end

  hamming_error_correction u_corr (
    .code_in     (sel_code),
    .parity_type (sel_parity),
    .code_out    (corr_code),
    .error       (corr_err)
  );

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_error_d  = out_error_q;
    out_chan_d   = out_chan_q;
    last_grant_d = last_grant_q;
    if (grant) begin
      state_d      = ST_FULL;
      out_data_d   = corr_code;
      out_error_d  = corr_err;
      out_chan_d   = gnt1;
      last_grant_d = gnt1;
    end else if (bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      out_data_q   <= '0;
      out_error_q  <= 1'b0;
      out_chan_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_error_q  <= out_error_d;
      out_chan_q   <= out_chan_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.out_valid  = (state_q == ST_FULL);
  assign bus.out_data   = out_data_q;
  assign bus.out_error  = out_error_q;
  assign bus.out_chan   = out_chan_q;

`ifdef HAMMING_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Clear wins over a same-cycle increment.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (cnt_clear) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (gnt0 && corr_err && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
      if (gnt1 && corr_err && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign err_cnt0 = cnt0_q;
  assign err_cnt1 = cnt1_q;
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = cnt_clear;
  assign err_cnt0 = '0;
  assign err_cnt1 = '0;
`endif

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
module tb_hamming_decode_arbiter;
  import hamming_pkg::*;

`ifdef HAMMING_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cnt_clear_a, cnt_clear_b;
  logic [15:0] err_cnt0_a, err_cnt1_a;
  logic [1:0]  err_cnt0_b, err_cnt1_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hamming_decode_arbiter_if ia ();
  hamming_decode_arbiter_if ib ();

  hamming_decode_arbiter #(.CNT_W(16), .PRIO_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ia), .cnt_clear(cnt_clear_a),
    .err_cnt0(err_cnt0_a), .err_cnt1(err_cnt1_a)
  );

  hamming_decode_arbiter #(.CNT_W(2), .PRIO_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ib), .cnt_clear(cnt_clear_b),
    .err_cnt0(err_cnt0_b), .err_cnt1(err_cnt1_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // One request on dut_a, starting and ending at a falling edge.
  task automatic send_a(input int ch, input logic [7:1] code, input logic pt,
                        input logic [7:1] exp_data, input logic exp_err);
    if (ch == 0) begin
      ia.req0_valid = 1'b1; ia.req0_code = code; ia.req0_parity_type = pt;
    end else begin
      ia.req1_valid = 1'b1; ia.req1_code = code; ia.req1_parity_type = pt;
    end
    #1;
    check_eq("req_ready", (ch == 0) ? ia.req0_ready : ia.req1_ready, 1);
    @(negedge clk);
    ia.req0_valid = 1'b0;
    ia.req1_valid = 1'b0;
    check_eq("out_valid", ia.out_valid, 1);
    check_eq("out_data", ia.out_data, exp_data);
    check_eq("out_error", ia.out_error, exp_err);
    check_eq("out_chan", ia.out_chan, ch);
  endtask

  initial begin
    rst = 1'b1;
    cnt_clear_a = 1'b0; cnt_clear_b = 1'b0;
    ia.req0_valid = 0; ia.req0_code = '0; ia.req0_parity_type = PARITY_EVEN;
    ia.req1_valid = 0; ia.req1_code = '0; ia.req1_parity_type = PARITY_EVEN;
    ia.out_ready = 1'b1;
    ib.req0_valid = 0; ib.req0_code = '0; ib.req0_parity_type = PARITY_EVEN;
    ib.req1_valid = 0; ib.req1_code = '0; ib.req1_parity_type = PARITY_EVEN;
    ib.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", ia.out_valid, 0);
    check_eq("rst_out_data", ia.out_data, 0);
    check_eq("rst_out_chan", ia.out_chan, 0);
    check_eq("rst_cnt0", err_cnt0_a, 0);
    check_eq("rst_cnt1", err_cnt1_a, 0);
    check_eq("rst_b_out_valid", ib.out_valid, 0);
    rst = 1'b0;

    // T1..T3
    send_a(0, 7'b0000000, PARITY_EVEN, 7'b0000000, 1'b0);
    check_eq("t1_cnt0", err_cnt0_a, 0);
    send_a(1, 7'b1011011, PARITY_EVEN, 7'b1001011, 1'b1);
    check_eq("t2_cnt1", err_cnt1_a, cnt_exp(1));
    send_a(1, 7'b1111111, PARITY_ODD, 7'b0111111, 1'b1);
    check_eq("t3_cnt1", err_cnt1_a, cnt_exp(2));

    // T4 round-robin: last grant was ch1, so ch0 goes first
    ia.req0_valid = 1; ia.req0_code = 7'b0000000; ia.req0_parity_type = PARITY_EVEN;
    ia.req1_valid = 1; ia.req1_code = 7'b1011011; ia.req1_parity_type = PARITY_EVEN;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_ready0", ia.req0_ready, (i % 2 == 0));
      check_eq("rr_ready1", ia.req1_ready, (i % 2 == 1));
      @(negedge clk);
      check_eq("rr_valid", ia.out_valid, 1);
      check_eq("rr_chan", ia.out_chan, i % 2);
    end
    ia.req0_valid = 0; ia.req1_valid = 0;
    @(negedge clk);
    check_eq("rr_drain", ia.out_valid, 0);
    check_eq("rr_cnt1", err_cnt1_a, cnt_exp(4));

    // T4 fixed priority on dut_b
    ib.req0_valid = 1; ib.req0_code = 7'b0000000;
    ib.req1_valid = 1; ib.req1_code = 7'b1011011;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("fp_ready1", ib.req1_ready, 0);
      @(negedge clk);
      check_eq("fp_chan", ib.out_chan, 0);
      check_eq("fp_valid", ib.out_valid, 1);
    end
    ib.req0_valid = 0; ib.req1_valid = 0;
    @(negedge clk);

    // T5 backpressure on dut_a
    ia.out_ready = 0;
    ia.req0_valid = 1; ia.req1_valid = 1;
    #1;
    check_eq("bp_first_ready0", ia.req0_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_ready0", ia.req0_ready, 0);
      check_eq("bp_ready1", ia.req1_ready, 0);
      check_eq("bp_valid", ia.out_valid, 1);
      check_eq("bp_chan", ia.out_chan, 0);
      check_eq("bp_data", ia.out_data, 7'b0000000);
      @(negedge clk);
    end
    ia.out_ready = 1;
    #1;
    check_eq("bp_rel_ready1", ia.req1_ready, 1);
    @(negedge clk);
    ia.req0_valid = 0; ia.req1_valid = 0;
    check_eq("bp_rel_chan", ia.out_chan, 1);
    check_eq("bp_rel_data", ia.out_data, 7'b1001011);
    check_eq("bp_rel_err", ia.out_error, 1);
    @(negedge clk);
    check_eq("bp_drain", ia.out_valid, 0);
    check_eq("bp_cnt1", err_cnt1_a, cnt_exp(5));
    check_eq("bp_cnt0", err_cnt0_a, 0);

    // T6 saturation on dut_b (2-bit counters)
    ib.req0_code = 7'b0000001; ib.req0_parity_type = PARITY_EVEN;
    for (int k = 0; k < 4; k++) begin
      ib.req0_valid = 1;
      @(negedge clk);
      ib.req0_valid = 0;
      check_eq("sat_data", ib.out_data, 7'b0000000);
      check_eq("sat_err", ib.out_error, 1);
      check_eq("sat_cnt0", err_cnt0_b, cnt_exp((k < 3) ? k + 1 : 3));
    end
    cnt_clear_b = 1; ib.req0_valid = 1;
    @(negedge clk);
    cnt_clear_b = 0; ib.req0_valid = 0;
    check_eq("clr_cnt0", err_cnt0_b, 0);
    ib.req0_valid = 1;
    @(negedge clk);
    ib.req0_valid = 0;
    check_eq("post_clr_cnt0", err_cnt0_b, cnt_exp(1));

    // reset while FULL and stalled
    ib.out_ready = 0;
    ib.req0_valid = 1;
    @(negedge clk);
    ib.req0_valid = 0;
    check_eq("pre_rst_valid", ib.out_valid, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_eq("mid_rst_valid", ib.out_valid, 0);
    check_eq("mid_rst_err", ib.out_error, 0);
    check_eq("mid_rst_cnt0", err_cnt0_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
